// File: rtl/downstream_req_fifo.sv
// Change-filtered request queue feeding a downstream RAM write port.
// A sample is queued only when it differs from the previous offered sample
// (or is the first after reset). Queued entries leave in strict arrival order.
// DEPTH must be a power of two in the range 2..16 so pointers wrap naturally.
module downstream_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4:0]              client_id,
  input  logic [15:0]             amount,
  input  logic                    mem_ready,
  output logic                    mem_valid,
  output logic                    mem_rw,
  output logic [13:0]             mem_wrindex,
  output logic [31:0]             mem_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Only client id and amount are stored; the rest of each request is constant.
  logic [4:0]  id_mem  [DEPTH];
  logic [15:0] amt_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          seen_q, seen_d;
  logic [4:0]    last_id_q, last_id_d;
  logic [15:0]   last_amt_q, last_amt_d;

  logic changed;
  logic full;
  logic pop;
  logic push;

  // Change detect, handshake and next-state computation.
  always_comb begin
    changed    = in_valid && (!seen_q || (client_id != last_id_q) || (amount != last_amt_q));
    full       = (count_q == FULL_CNT);
    pop        = (count_q != '0) && mem_ready;
    // At full, a same-edge pop frees the slot the new sample needs.
    push       = changed && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q || (changed && !push);

    seen_d     = seen_q || in_valid;
    last_id_d  = in_valid ? client_id : last_id_q;
    last_amt_d = in_valid ? amount    : last_amt_q;
  end

  // Control state with synchronous active-low reset; reset-cycle samples are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      seen_q     <= 1'b0;
      last_id_q  <= '0;
      last_amt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      seen_q     <= seen_d;
      last_id_q  <= last_id_d;
      last_amt_q <= last_amt_d;
    end
  end

  // Queue storage; contents are left as-is by reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      id_mem[wr_ptr_q]  <= client_id;
      amt_mem[wr_ptr_q] <= amount;
    end
  end

  // Head request comes straight from stored entries; zeroed while the queue is empty.
  always_comb begin
    mem_valid   = (count_q != '0);
    mem_rw      = mem_valid;
    mem_wrindex = '0;
    mem_data    = '0;
    if (mem_valid) begin
      mem_wrindex = {5'b0, id_mem[rd_ptr_q], 4'b0000};
      mem_data    = {16'b0, amt_mem[rd_ptr_q]};
    end
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_downstream_req_fifo.sv
// Directed bench for downstream_req_fifo at DEPTH=4.
module tb_downstream_req_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  client_id;
  logic [15:0] amount;
  logic        mem_ready;
  logic        mem_valid;
  logic        mem_rw;
  logic [13:0] mem_wrindex;
  logic [31:0] mem_data;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  downstream_req_fifo #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .client_id   (client_id),
    .amount      (amount),
    .mem_ready   (mem_ready),
    .mem_valid   (mem_valid),
    .mem_rw      (mem_rw),
    .mem_wrindex (mem_wrindex),
    .mem_data    (mem_data),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [2:0] cnt, input logic [13:0] idx,
                          input logic [31:0] dat);
    chk({tag, " count"},   {29'b0, count}, {29'b0, cnt});
    chk({tag, " valid"},   {31'b0, mem_valid}, {31'b0, (cnt != 3'd0)});
    chk({tag, " rw"},      {31'b0, mem_rw}, {31'b0, (cnt != 3'd0)});
    chk({tag, " wrindex"}, {18'b0, mem_wrindex}, {18'b0, idx});
    chk({tag, " data"},    mem_data, dat);
  endtask

  task automatic offer(input logic [4:0] id, input logic [15:0] amt, input logic rdy);
    in_valid  = 1'b1;
    client_id = id;
    amount    = amt;
    mem_ready = rdy;
    tick();
  endtask

  task automatic idle(input logic rdy);
    in_valid  = 1'b0;
    mem_ready = rdy;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; client_id = '0; amount = '0; mem_ready = 1'b0;
    tick();
    tick();
    chk_head("reset", 3'd0, 14'h0, 32'h0);
    chk("reset overflow", {31'b0, overflow}, 32'h0);

    // First sample with mem_ready low: one-cycle latency to the head.
    rst_n = 1'b1;
    offer(5'd3, 16'd100, 1'b0);
    chk_head("first push", 3'd1, 14'h0030, 32'd100);

    // Repeated identical sample is filtered.
    for (int i = 0; i < 3; i++) begin
      offer(5'd3, 16'd100, 1'b0);
      chk_head("repeat", 3'd1, 14'h0030, 32'd100);
    end

    // Fill to full, then one more changed sample is dropped.
    offer(5'd4, 16'd1, 1'b0);
    offer(5'd5, 16'd2, 1'b0);
    offer(5'd6, 16'd3, 1'b0);
    chk_head("full", 3'd4, 14'h0030, 32'd100);
    chk("full overflow", {31'b0, overflow}, 32'h0);
    offer(5'd7, 16'd4, 1'b0);
    chk_head("drop held", 3'd4, 14'h0030, 32'd100);
    chk("drop overflow", {31'b0, overflow}, 32'h1);

    // Drain: first four in order, fifth never appears.
    idle(1'b1);
    chk_head("drain1", 3'd3, 14'h0040, 32'd1);
    idle(1'b1);
    chk_head("drain2", 3'd2, 14'h0050, 32'd2);
    idle(1'b1);
    chk_head("drain3", 3'd1, 14'h0060, 32'd3);
    idle(1'b1);
    chk_head("drain4", 3'd0, 14'h0, 32'h0);
    chk("sticky overflow", {31'b0, overflow}, 32'h1);

    // Reset clears overflow; then full plus simultaneous push/pop.
    rst_n = 1'b0;
    idle(1'b0);
    chk("rst overflow", {31'b0, overflow}, 32'h0);
    rst_n = 1'b1;
    offer(5'd1, 16'd10, 1'b0);
    offer(5'd2, 16'd20, 1'b0);
    offer(5'd3, 16'd30, 1'b0);
    offer(5'd4, 16'd40, 1'b0);
    chk_head("full2", 3'd4, 14'h0010, 32'd10);
    offer(5'd9, 16'd90, 1'b1);
    chk_head("full pushpop", 3'd4, 14'h0020, 32'd20);
    chk("full pushpop overflow", {31'b0, overflow}, 32'h0);
    idle(1'b1);
    chk_head("wrap1", 3'd3, 14'h0030, 32'd30);
    idle(1'b1);
    chk_head("wrap2", 3'd2, 14'h0040, 32'd40);
    idle(1'b1);
    chk_head("wrap tail", 3'd1, 14'h0090, 32'd90);
    idle(1'b1);
    chk_head("wrap empty", 3'd0, 14'h0, 32'h0);

    // Alternating samples with mem_ready held high; empty push ignores ready.
    offer(5'd1, 16'd5, 1'b1);
    chk_head("alt1", 3'd1, 14'h0010, 32'd5);
    offer(5'd2, 16'd5, 1'b1);
    chk_head("alt2", 3'd1, 14'h0020, 32'd5);
    offer(5'd1, 16'd5, 1'b1);
    chk_head("alt3", 3'd1, 14'h0010, 32'd5);
    offer(5'd2, 16'd5, 1'b1);
    chk_head("alt4", 3'd1, 14'h0020, 32'd5);
    idle(1'b1);
    chk_head("alt drained", 3'd0, 14'h0, 32'h0);

    // Reset with three queued; the same sample afterwards is queued again.
    offer(5'd7, 16'd7, 1'b0);
    offer(5'd8, 16'd8, 1'b0);
    offer(5'd9, 16'd9, 1'b0);
    chk_head("pre-reset", 3'd3, 14'h0070, 32'd7);
    rst_n = 1'b0;
    offer(5'd9, 16'd9, 1'b1);
    chk_head("mid reset", 3'd0, 14'h0, 32'h0);
    chk("mid reset overflow", {31'b0, overflow}, 32'h0);
    rst_n = 1'b1;
    offer(5'd9, 16'd9, 1'b0);
    chk_head("post-reset same", 3'd1, 14'h0090, 32'd9);
    offer(5'd9, 16'd9, 1'b0);
    chk_head("post-reset repeat", 3'd1, 14'h0090, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
